// File: rtl/diff_oser_lanes_pkg.sv
// Shared definitions for the differential output serializer: FSM encodings,
// the PRBS7 polynomial and seed, and the default idle word.
package diff_oser_lanes_pkg;

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_IDLE = 2'd1,
        ST_DATA = 2'd2
    } oser_state_t;

    // Feedback taps for x^7 + x^6 + 1
    localparam logic [6:0] PRBS7_POLY = 7'b110_0000;
    localparam logic [6:0] PRBS7_SEED = 7'h7F;

    localparam logic [7:0] IDLE_PATTERN_DEFAULT = 8'b1010_1010;

    // Next PRBS bit is the tap parity; it also becomes the new register LSB.
    function automatic logic prbs7_bit(input logic [6:0] s);
        return ^(s & PRBS7_POLY);
    endfunction

    function automatic logic [6:0] prbs7_next(input logic [6:0] s);
        return {s[5:0], prbs7_bit(s)};
    endfunction

endpackage

// File: rtl/diff_oser_lane.sv
// One serializer lane: MSB-first shift register feeding a complementary
// O/OB pair with optional polarity swap and a shared tristate enable.
module diff_oser_lane #(
    parameter int               WIDTH      = 8,
    parameter logic [WIDTH-1:0] RESET_WORD = '0,
    parameter logic             INVERT     = 1'b0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_word,
    input  logic             i_tq,
    output wire              o_o,
    output wire              o_ob
);

    logic [WIDTH-1:0] r_shift;
    logic             w_bit;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_shift <= RESET_WORD;
        end else if (i_load) begin
            r_shift <= i_word;
        end else begin
            r_shift <= {r_shift[WIDTH-2:0], 1'b0};
        end
    end

    assign w_bit = r_shift[WIDTH-1] ^ INVERT;
    assign o_o   = i_tq ? 1'bz : w_bit;
    assign o_ob  = i_tq ? 1'bz : ~w_bit;

endmodule

// File: rtl/diff_oser_lanes.sv
// Multi-lane differential serializer: bit counter, OFF/IDLE/DATA FSM, word
// handshake and lane array. Define DIFF_OSER_PRBS_EN to add a PRBS7 test source.
module diff_oser_lanes
    import diff_oser_lanes_pkg::*;
#(
    parameter int               LANES        = 4,
    parameter int               WIDTH        = 8,
    parameter logic [WIDTH-1:0] IDLE_PATTERN = WIDTH'(IDLE_PATTERN_DEFAULT),
    parameter logic [LANES-1:0] INV_MASK     = '0
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic [LANES*WIDTH-1:0] D,
    input  logic                   D_VALID,
    output logic                   D_READY,
    input  logic                   T,
`ifdef DIFF_OSER_PRBS_EN
    input  logic                   PRBS_MODE,
`endif
    output wire  [LANES-1:0]       O,
    output wire  [LANES-1:0]       OB,
    output logic                   TQ,
    output logic                   UNDERRUN
);

    localparam int               CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);

    logic [CW-1:0]    r_cnt;
    oser_state_t      r_state;
    oser_state_t      w_state_next;
    logic             r_tq;
    logic             r_underrun;
    logic             w_underrun_next;
    logic             w_load_slot;
    logic             w_xfer;
    logic             w_lane_load;
    logic             w_prbs_mode;
    logic             w_prbs_active;
    logic [WIDTH-1:0] w_fill_word;

    assign w_load_slot = (r_cnt == CNT_LAST);

`ifdef DIFF_OSER_PRBS_EN
    logic [6:0]       r_prbs;
    logic [6:0]       w_prbs_next;
    logic [WIDTH-1:0] w_prbs_word;

    assign w_prbs_mode   = PRBS_MODE;
    assign w_prbs_active = PRBS_MODE && (r_state != ST_OFF);

    // Unroll WIDTH LFSR steps; the first generated bit lands in the word MSB.
    always_comb begin
        w_prbs_next = r_prbs;
        w_prbs_word = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            w_prbs_word[i] = prbs7_bit(w_prbs_next);
            w_prbs_next    = prbs7_next(w_prbs_next);
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_prbs <= PRBS7_SEED;
        end else if (w_load_slot && w_prbs_active) begin
            r_prbs <= w_prbs_next;
        end
    end

    assign w_fill_word = w_prbs_active ? w_prbs_word : IDLE_PATTERN;
`else
    assign w_prbs_mode   = 1'b0;
    assign w_prbs_active = 1'b0;
    assign w_fill_word   = IDLE_PATTERN;
`endif

    assign D_READY = w_load_slot && !T && (r_state != ST_OFF) && !w_prbs_mode;
    assign w_xfer  = D_READY && D_VALID;

    // Leaving OFF also reloads the idle word so the first driven slot is clean.
    assign w_lane_load = w_load_slot && (w_xfer || (r_state != ST_OFF) || !T);

    always_comb begin
        w_state_next    = r_state;
        w_underrun_next = 1'b0;
        if (w_load_slot) begin
            case (r_state)
                ST_OFF: begin
                    if (!T) w_state_next = ST_IDLE;
                end
                ST_IDLE: begin
                    if (T)           w_state_next = ST_OFF;
                    else if (w_xfer) w_state_next = ST_DATA;
                end
                ST_DATA: begin
                    if (T) begin
                        w_state_next = ST_OFF;
                    end else if (w_xfer) begin
                        w_state_next = ST_DATA;
                    end else begin
                        w_state_next    = ST_IDLE;
                        w_underrun_next = !w_prbs_mode;
                    end
                end
                default: w_state_next = ST_OFF;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_cnt      <= CNT_LAST;
            r_state    <= ST_OFF;
            r_tq       <= 1'b1;
            r_underrun <= 1'b0;
        end else begin
            r_cnt      <= w_load_slot ? '0 : r_cnt + 1'b1;
            r_state    <= w_state_next;
            r_tq       <= (w_state_next == ST_OFF);
            r_underrun <= w_underrun_next;
        end
    end

    assign TQ       = r_tq;
    assign UNDERRUN = r_underrun;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic [WIDTH-1:0] w_word;

            assign w_word = w_xfer ? D[gi*WIDTH +: WIDTH] : w_fill_word;

            diff_oser_lane #(
                .WIDTH      (WIDTH),
                .RESET_WORD (IDLE_PATTERN),
                .INVERT     (INV_MASK[gi])
            ) u_lane (
                .i_clk   (CLK),
                .i_rst_n (RST_N),
                .i_load  (w_lane_load),
                .i_word  (w_word),
                .i_tq    (r_tq),
                .o_o     (O[gi]),
                .o_ob    (OB[gi])
            );
        end
    endgenerate

endmodule
